apb_req_master: RTL and testbench

- Simple request-to-APB bridge master that drives one APB3 slave port (PSEL/PENABLE/PWRITE/PADDR/PWDATA) from a single-outstanding valid/ready request interface.
- Returns read data, or an error status, on a one-cycle response strobe.
- Sits directly upstream of the APB slave models and peripherals in the CoreABC test and DDR-control subsystems.
- Guarantees APB protocol compliance: stable address/control across SETUP and ACCESS, one PENABLE cycle per zero-wait transfer, mandatory IDLE between transfers.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_timeout_cnt.sv | 33 +++
 rtl/apb_req_master.sv | 134 +++++++++++++
 tb/tb_apb_req_master.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the request-to-APB master: FSM state encoding
// and sizing of the ACCESS wait-state timeout counter.
package apb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        APB_IDLE   = ST_IDLE,
        APB_SETUP  = ST_SETUP,
        APB_ACCESS = ST_ACCESS
    } apb_state_e;

    // A disabled timeout (0) still gets a 1-bit counter so the port widths stay legal.
    function automatic int tmo_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Purpose: counts ACCESS cycles with PREADY low and flags the last permitted one.
// Latency: expire is combinational from the current count and en.
// Backpressure: none; clr has priority over en.
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESETN,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = tmo_cnt_w(int'(TIMEOUT));

    logic [CW-1:0] cnt;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // The cycle holding count TIMEOUT-1 is the TIMEOUT-th stalled ACCESS cycle.
    assign expire = (TIMEOUT != 0) && en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_req_master.sv
// Purpose: single-outstanding valid/ready request to APB3 master bridge.
// Latency: accept in cycle N -> SETUP N+1, ACCESS N+2, RSP_VALID N+3 plus one per wait state.
// Backpressure: REQ_READY only in IDLE; RSP_VALID is a one-cycle strobe with no backpressure.
module apb_req_master
    import apb_pkg::*;
#(
    parameter int unsigned AWIDTH  = 8,
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [AWIDTH-1:0] REQ_ADDR,
    input  logic [DWIDTH-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    output logic [DWIDTH-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e        state;
    apb_state_e        state_nxt;

    logic              req_ready_nxt;
    logic              psel_nxt;
    logic              penable_nxt;
    logic              pwrite_nxt;
    logic [AWIDTH-1:0] paddr_nxt;
    logic [DWIDTH-1:0] pwdata_nxt;
    logic              rsp_valid_nxt;
    logic [DWIDTH-1:0] rsp_rdata_nxt;
    logic              rsp_err_nxt;

    logic              req_accept;
    logic              tmo_clr;
    logic              tmo_en;
    logic              tmo_expire;

    assign req_accept = (state == APB_IDLE) && REQ_VALID && REQ_READY;
    assign tmo_clr    = (state != APB_ACCESS);
    assign tmo_en     = (state == APB_ACCESS) && !PREADY;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expire  (tmo_expire)
    );

    always_comb begin
        state_nxt     = state;
        pwrite_nxt    = PWRITE;
        paddr_nxt     = PADDR;
        pwdata_nxt    = PWDATA;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = RSP_RDATA;
        rsp_err_nxt   = RSP_ERR;

        case (state)
            APB_IDLE: begin
                if (req_accept) begin
                    state_nxt  = APB_SETUP;
                    pwrite_nxt = REQ_WRITE;
                    paddr_nxt  = REQ_ADDR;
                    pwdata_nxt = REQ_WDATA;
                end
            end
            APB_SETUP: begin
                state_nxt = APB_ACCESS;
            end
            APB_ACCESS: begin
                // A slave completing on the expiry cycle wins over the abort.
                if (PREADY) begin
                    state_nxt     = APB_IDLE;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
                    rsp_err_nxt   = PSLVERR;
                end else if (tmo_expire) begin
                    state_nxt     = APB_IDLE;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = APB_IDLE;
            end
        endcase

        req_ready_nxt = (state_nxt == APB_IDLE);
        psel_nxt      = (state_nxt != APB_IDLE);
        penable_nxt   = (state_nxt == APB_ACCESS);
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state     <= APB_IDLE;
            REQ_READY <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            state     <= state_nxt;
            REQ_READY <= req_ready_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            PWRITE    <= pwrite_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
            RSP_VALID <= rsp_valid_nxt;
            RSP_RDATA <= rsp_rdata_nxt;
            RSP_ERR   <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: APB slave model with programmable wait states,
// a transaction-level reference model checked every cycle, plus directed literal checks.
module tb_apb_req_master;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 4;

    logic          PCLK      = 1'b0;
    logic          PRESETN   = 1'b0;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WRITE = 1'b0;
    logic [AW-1:0] REQ_ADDR  = '0;
    logic [DW-1:0] REQ_WDATA = '0;
    logic          RSP_VALID;
    logic [DW-1:0] RSP_RDATA;
    logic          RSP_ERR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA    = '0;
    logic          PREADY    = 1'b1;
    logic          PSLVERR   = 1'b0;

    apb_req_master #(
        .AWIDTH  (AW),
        .DWIDTH  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WRITE (REQ_WRITE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERR   (RSP_ERR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial forever #5 PCLK = ~PCLK;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    initial forever begin
        @(posedge PCLK);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- APB slave model ----------------
    int         cfg_waits = 0;
    logic       cfg_err   = 1'b0;
    logic [7:0] smem [256] = '{default: 8'h00};
    logic [7:0] setup_addr = 8'h00;
    int         acc_n      = 0;

    initial forever begin
        @(posedge PCLK);
        if (PRESETN && PSEL && PENABLE && PREADY && PWRITE) smem[PADDR] = PWDATA;
        #1;
        if (PSEL && PENABLE) begin
            acc_n++;
            chk("apb_addr_stable", 32'(PADDR), 32'(setup_addr));
        end else begin
            acc_n = 0;
            if (PSEL) setup_addr = PADDR;
        end
        PREADY  = (PSEL && PENABLE) ? (acc_n > cfg_waits) : 1'b1;
        PSLVERR = cfg_err;
        PRDATA  = smem[PADDR];
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit         m_busy  = 1'b0;
    bit         m_armed = 1'b0;
    int         m_acc   = 0;
    int         m_len   = 0;
    logic       m_pwrite = 1'b0;
    logic [7:0] m_paddr  = 8'h00;
    logic [7:0] m_pwdata = 8'h00;
    logic [7:0] m_rdata  = 8'h00;
    logic       m_err    = 1'b0;
    logic [7:0] m_rsp_rdata = 8'h00;
    logic       m_rsp_err   = 1'b0;
    logic [7:0] m_mem [256] = '{default: 8'h00};

    initial forever begin
        logic e_ready, e_psel, e_pen, e_rsp;
        int   rel;
        bit   abort;
        @(negedge PCLK);
        e_ready = 1'b0; e_psel = 1'b0; e_pen = 1'b0; e_rsp = 1'b0;
        if (!PRESETN) begin
            m_busy = 1'b0; m_armed = 1'b0;
            m_pwrite = 1'b0; m_paddr = 8'h00; m_pwdata = 8'h00;
            m_rdata = 8'h00; m_err = 1'b0;
        end else if (m_busy) begin
            rel     = cyc - m_acc;
            e_psel  = (rel >= 1) && (rel <= 1 + m_len);
            e_pen   = (rel >= 2) && (rel <= 1 + m_len);
            e_rsp   = (rel == 2 + m_len);
            e_ready = (rel >= 2 + m_len);
        end else begin
            e_ready = m_armed;
        end
        if (e_rsp) begin
            m_rdata = m_rsp_rdata;
            m_err   = m_rsp_err;
        end

        chk("req_ready", 32'(REQ_READY), 32'(e_ready));
        chk("psel",      32'(PSEL),      32'(e_psel));
        chk("penable",   32'(PENABLE),   32'(e_pen));
        chk("rsp_valid", 32'(RSP_VALID), 32'(e_rsp));
        chk("rsp_rdata", 32'(RSP_RDATA), 32'(m_rdata));
        chk("rsp_err",   32'(RSP_ERR),   32'(m_err));
        chk("pwrite",    32'(PWRITE),    32'(m_pwrite));
        chk("paddr",     32'(PADDR),     32'(m_paddr));
        chk("pwdata",    32'(PWDATA),    32'(m_pwdata));

        if (PRESETN) begin
            m_armed = 1'b1;
            if (e_rsp) m_busy = 1'b0;
            if (!m_busy && e_ready && REQ_VALID) begin
                abort    = (cfg_waits >= TMO);
                m_busy   = 1'b1;
                m_acc    = cyc;
                m_len    = abort ? TMO : cfg_waits + 1;
                m_pwrite = REQ_WRITE;
                m_paddr  = REQ_ADDR;
                m_pwdata = REQ_WDATA;
                if (abort) begin
                    m_rsp_rdata = 8'h00;
                    m_rsp_err   = 1'b1;
                end else begin
                    m_rsp_rdata = REQ_WRITE ? 8'h00 : m_mem[REQ_ADDR];
                    m_rsp_err   = cfg_err;
                    if (REQ_WRITE) m_mem[REQ_ADDR] = REQ_WDATA;
                end
            end
        end
    end

    // ---------------- run-length / response monitor ----------------
    int pen_run = 0, pen_last = 0, psel_run = 0, psel_last = 0;
    int rsp_q[$];

    initial forever begin
        @(negedge PCLK);
        if (RSP_VALID) rsp_q.push_back(cyc);
        if (PENABLE) pen_run++;
        else if (pen_run > 0) begin pen_last = pen_run; pen_run = 0; end
        if (PSEL) psel_run++;
        else if (psel_run > 0) begin psel_last = psel_run; psel_run = 0; end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin @(negedge PCLK); n++; end while (!REQ_READY && n < 40);
        chk("accept_wait", 32'(REQ_READY), 1);
    endtask

    task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input int waits, input logic err,
                          output int lat, output logic [7:0] rd, output logic re);
        int acc_c;
        int n = 0;
        cfg_waits = waits;
        cfg_err   = err;
        REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_WDATA = d;
        wait_ready();
        acc_c = cyc;
        step();
        REQ_VALID = 1'b0; REQ_WRITE = ~w; REQ_ADDR = ~a; REQ_WDATA = ~d;
        do begin @(negedge PCLK); n++; end while (!RSP_VALID && n < 40);
        chk("rsp_wait", 32'(RSP_VALID), 1);
        lat = cyc - acc_c;
        rd  = RSP_RDATA;
        re  = RSP_ERR;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int         lat;
        logic [7:0] rd;
        logic       re;
        int         acc [4];

        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_psel",      32'(PSEL),      0);
        chk("reset_ready",     32'(REQ_READY), 0);
        chk("reset_rsp_valid", 32'(RSP_VALID), 0);
        PRESETN = 1'b1;
        step();
        chk("ready_after_release", 32'(REQ_READY), 1);

        // zero-wait write then read
        do_req(1'b1, 8'h12, 8'hA5, 0, 1'b0, lat, rd, re);
        chk("wr0_latency", lat, 3);
        chk("wr0_rdata", 32'(rd), 0);
        chk("wr0_err", 32'(re), 0);
        step();
        chk("wr0_psel_len", psel_last, 2);
        do_req(1'b0, 8'h12, 8'h00, 0, 1'b0, lat, rd, re);
        chk("rd0_latency", lat, 3);
        chk("rd0_rdata", 32'(rd), 'hA5);
        chk("rd0_err", 32'(re), 0);
        step();
        chk("rd0_psel_len", psel_last, 2);

        // wait states: three stalls, completes on the last permitted ACCESS cycle
        do_req(1'b1, 8'h34, 8'h5C, 3, 1'b0, lat, rd, re);
        chk("ws3_latency", lat, 6);
        step();
        chk("ws3_penable_len", pen_last, 4);
        do_req(1'b0, 8'h34, 8'h00, 2, 1'b0, lat, rd, re);
        chk("ws2_latency", lat, 5);
        chk("ws2_rdata", 32'(rd), 'h5C);
        step();

        // timeout with PREADY stuck low
        do_req(1'b0, 8'h12, 8'h00, 99, 1'b0, lat, rd, re);
        chk("tmo_latency", lat, 2 + TMO);
        chk("tmo_rdata", 32'(rd), 0);
        chk("tmo_err", 32'(re), 1);
        chk("tmo_psel_at_rsp", 32'(PSEL), 0);
        chk("tmo_ready_at_rsp", 32'(REQ_READY), 1);
        step();
        chk("tmo_penable_len", pen_last, TMO);

        // back-to-back with REQ_VALID held high
        cfg_waits = 0;
        cfg_err   = 1'b0;
        rsp_q.delete();
        REQ_VALID = 1'b1;
        REQ_WRITE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            REQ_ADDR  = 8'(i);
            REQ_WDATA = 8'hC0 + 8'(i);
            wait_ready();
            acc[i] = cyc;
            step();
        end
        REQ_VALID = 1'b0;
        repeat (6) step();
        chk("b2b_rsp_count", rsp_q.size(), 4);
        chk("b2b_accept_span", acc[3] - acc[0], 9);
        chk("b2b_first_latency", (rsp_q.size() > 0) ? rsp_q[0] - acc[0] : -1, 3);
        for (int i = 1; i < 4; i++)
            chk("b2b_rsp_spacing", (rsp_q.size() > i) ? rsp_q[i] - rsp_q[i-1] : -1, 3);
        do_req(1'b0, 8'h02, 8'h00, 0, 1'b0, lat, rd, re);
        chk("b2b_readback", 32'(rd), 'hC2);
        step();

        // slave error on a read, then a clean transfer
        do_req(1'b0, 8'h12, 8'h00, 0, 1'b1, lat, rd, re);
        chk("slverr_err", 32'(re), 1);
        chk("slverr_rdata", 32'(rd), 'hA5);
        step();
        do_req(1'b0, 8'h34, 8'h00, 0, 1'b0, lat, rd, re);
        chk("post_slverr_err", 32'(re), 0);
        chk("post_slverr_rdata", 32'(rd), 'h5C);
        step();

        // asynchronous reset during wait states
        cfg_waits = 99;
        REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 8'h12;
        wait_ready();
        step();
        REQ_VALID = 1'b0;
        step();
        step();
        chk("pre_reset_penable", 32'(PENABLE), 1);
        #2;
        PRESETN = 1'b0;
        #1;
        chk("async_rst_psel", 32'(PSEL), 0);
        chk("async_rst_penable", 32'(PENABLE), 0);
        chk("async_rst_rsp_valid", 32'(RSP_VALID), 0);
        rsp_q.delete();
        step();
        step();
        PRESETN   = 1'b1;
        cfg_waits = 0;
        repeat (3) step();
        chk("post_rst_ready", 32'(REQ_READY), 1);
        repeat (5) step();
        chk("post_rst_no_rsp", rsp_q.size(), 0);

        do_req(1'b0, 8'h12, 8'h00, 0, 1'b0, lat, rd, re);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_rdata", 32'(rd), 'hA5);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
